// File: rtl/cpu19_pkg.sv
// Shared types and constants for the 19-bit CPU front end.
package cpu19_pkg;
    localparam int             XLEN        = 19;
    localparam int             OPCODE_W    = 5;
    localparam logic [4:0]     HALT_OPCODE = 5'h1F;
    localparam logic [18:0]    RESET_PC    = 19'h0;

    localparam int             OPC_MSB     = 18;
    localparam int             OPC_LSB     = 14;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register for {pc, instr, valid} with hold/flush/load control.
// Priority: rst > flush > hold > load; with none asserted the slot goes invalid.
module if_id_reg #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] instr_i,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] instr_o,
    output logic         valid_o
);
    logic [W-1:0] pc_q, instr_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end else begin
            // Payload kept, only the valid bit drops (bubble).
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// PC register, fetch FSM and IF/ID register for the 19-bit CPU.
// Instruction memory is combinational: instr_in corresponds to pc_out this cycle.
module fetch_stage
    import cpu19_pkg::*;
#(
    parameter int               XLEN        = cpu19_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC    = cpu19_pkg::RESET_PC,
    parameter int               MEM_WORDS   = 1024,
    parameter int               OPCODE_W    = cpu19_pkg::OPCODE_W,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = cpu19_pkg::HALT_OPCODE
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_out,
    input  logic [XLEN-1:0] instr_in,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            halted,
    output logic            fetch_fault
);
    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fault_q, fault_d;
    logic             hold, flush, load;
    logic             oob, is_halt;
    logic [OPCODE_W-1:0] opcode;

    assign opcode  = instr_in[OPC_MSB:OPC_LSB];
    assign is_halt = (opcode == HALT_OPCODE);
    assign oob     = (32'(pc_q[XLEN-1:2]) >= MEM_WORDS);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        hold    = 1'b0;
        flush   = 1'b0;
        load    = 1'b0;
        if (state_q == BOOT) begin
            // Redirects are ignored in BOOT; stall still freezes everything.
            hold = 1'b1;
            if (!stall) state_d = RUN;
        end else if (redirect) begin
            flush   = 1'b1;
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            state_d = RUN;
            fault_d = 1'b0;
        end else if (stall) begin
            hold = 1'b1;
        end else if (state_q == RUN) begin
            if (oob) begin
                fault_d = 1'b1;
                state_d = HALTED;
            end else begin
                load = 1'b1;
                if (is_halt) state_d = HALTED;
                else         pc_d    = pc_q + XLEN'(4);
            end
        end
        // HALTED with no redirect/stall: neither hold nor load, so valid drops.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg #(.W(XLEN)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (hold),
        .flush_i (flush),
        .load_i  (load),
        .pc_i    (pc_q),
        .instr_i (instr_in),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

    assign pc_out      = pc_q;
    assign halted      = (state_q == HALTED);
    assign fetch_fault = fault_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed test-plan walk followed by random stimulus, checked against a
// cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;
    localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2;
    localparam int WORDS  = 1024;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [18:0] redirect_pc, pc_out, instr_in;
    logic [18:0] if_id_pc, if_id_instr;
    logic        if_id_valid, halted, fetch_fault;

    logic [18:0] mem [WORDS];

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_pc, m_st;
    logic [18:0] m_ipc, m_instr;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    assign instr_in = (pc_out[18:2] < 17'(WORDS)) ? mem[pc_out[11:2]] : 19'h0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_out      (pc_out),
        .instr_in    (instr_in),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_fault (fetch_fault)
    );

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] rand_word();
        logic [18:0] w;
        w = 19'($urandom);
        if (w[18:14] == 5'h1F) w[14] = 1'b0;
        return w;
    endfunction

    // Advance one clock: compute the model's next state from the rules, then compare.
    task automatic step();
        int          npc, nst, idx;
        logic [18:0] nipc, ninstr, w;
        logic        nv, nf;
        npc = m_pc; nst = m_st; nipc = m_ipc; ninstr = m_instr; nv = m_valid; nf = m_fault;
        if (rst) begin
            npc = 0; nst = S_BOOT; nipc = '0; ninstr = '0; nv = 1'b0; nf = 1'b0;
        end else if (m_st == S_BOOT) begin
            if (!stall) nst = S_RUN;
        end else if (redirect) begin
            npc = int'(redirect_pc) & 32'h7FFFC;
            nv = 1'b0; nipc = '0; ninstr = '0; nst = S_RUN; nf = 1'b0;
        end else if (stall) begin
            // everything held
        end else if (m_st == S_RUN) begin
            idx = m_pc / 4;
            if (idx >= WORDS) begin
                nf = 1'b1; nv = 1'b0; nst = S_HALT;
            end else begin
                w = mem[idx];
                nipc = 19'(m_pc); ninstr = w; nv = 1'b1;
                if (w[18:14] == 5'h1F) nst = S_HALT;
                else                   npc = (m_pc + 4) % (1 << 19);
            end
        end else begin
            nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_st = nst; m_ipc = nipc; m_instr = ninstr; m_valid = nv; m_fault = nf;
        chk("pc_out",      pc_out,             19'(m_pc));
        chk("if_id_pc",    if_id_pc,           m_ipc);
        chk("if_id_instr", if_id_instr,        m_instr);
        chk("if_id_valid", 19'(if_id_valid),   19'(m_valid));
        chk("halted",      19'(halted),        19'(m_st == S_HALT));
        chk("fetch_fault", 19'(fetch_fault),   19'(m_fault));
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = rand_word();
        mem[0] = 19'h00001; mem[1] = 19'h00002; mem[2] = 19'h00003; mem[3] = 19'h00004;
        mem[4] = 19'h7C000;
        m_pc = 0; m_st = S_BOOT; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_fault = 1'b0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // 1. reset then straight-line
        step(); step();
        chk("rst_pc", pc_out, 19'h0);
        rst = 1'b0;
        step();
        chk("boot_valid", 19'(if_id_valid), 19'h0);
        chk("boot_pc", pc_out, 19'h0);
        step();
        chk("seq_pc4", pc_out, 19'h4);
        chk("seq_instr1", if_id_instr, 19'h00001);
        step();
        chk("seq_pc8", pc_out, 19'h8);
        chk("seq_instr2", if_id_instr, 19'h00002);

        // 2. stall
        stall = 1'b1;
        step(); step(); step();
        chk("stall_pc", pc_out, 19'h8);
        chk("stall_ifpc", if_id_pc, 19'h4);
        chk("stall_valid", 19'(if_id_valid), 19'h1);
        stall = 1'b0;
        step();
        chk("resume_instr3", if_id_instr, 19'h00003);
        chk("resume_pc", pc_out, 19'hC);

        // 3. redirect beats stall, misaligned target
        redirect = 1'b1; redirect_pc = 19'h00103; stall = 1'b1;
        step();
        chk("redir_pc", pc_out, 19'h00100);
        chk("redir_bubble", 19'(if_id_valid), 19'h0);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("redir_ifpc", if_id_pc, 19'h00100);
        chk("redir_valid", 19'(if_id_valid), 19'h1);

        // 4. HALT then redirect out
        redirect = 1'b1; redirect_pc = 19'h00010;
        step();
        redirect = 1'b0;
        step();
        chk("halt_instr", if_id_instr, 19'h7C000);
        chk("halt_valid", 19'(if_id_valid), 19'h1);
        step();
        chk("halt_bubble", 19'(if_id_valid), 19'h0);
        chk("halt_flag", 19'(halted), 19'h1);
        chk("halt_pc", pc_out, 19'h00010);
        step();
        redirect = 1'b1; redirect_pc = 19'h00020;
        step();
        chk("unhalt", 19'(halted), 19'h0);
        chk("unhalt_pc", pc_out, 19'h00020);

        // 5. out-of-range fault
        redirect_pc = 19'h01000;
        step();
        redirect = 1'b0;
        step();
        chk("fault", 19'(fetch_fault), 19'h1);
        chk("fault_halted", 19'(halted), 19'h1);
        rst = 1'b1;
        step();
        chk("fault_clear", 19'(fetch_fault), 19'h0);
        chk("fault_rst_pc", pc_out, 19'h0);

        // 6. reset while stalled with a valid instruction
        rst = 1'b0;
        step(); step();
        chk("pre_rst_valid", 19'(if_id_valid), 19'h1);
        rst = 1'b1; stall = 1'b1;
        step();
        chk("rst_stall_valid", 19'(if_id_valid), 19'h0);
        chk("rst_stall_instr", if_id_instr, 19'h0);
        rst = 1'b0; stall = 1'b0;

        // Random phase: sprinkle HALTs, random stalls/redirects/resets.
        for (int i = 0; i < WORDS; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? (19'h7C000 | 19'($urandom_range(0, 16383)))
                                                  : rand_word();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 6) == 0) redirect_pc = 19'($urandom);
            else redirect_pc = 19'($urandom_range(0, WORDS * 4 - 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
